// File: rtl/morse_symbol_packer.sv
// morse_symbol_packer
// Conditions the raw player/mode keys, tracks the current symbol mode and
// packs up to four 2-bit symbols into one Morse letter. A letter closes when
// its fourth symbol arrives or when no symbol arrives for GAP_CYCLES clocks.
// Slot 0 of a letter occupies [7:6] and slot 3 occupies [1:0].
module morse_symbol_packer #(
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned MAX_SYMBOLS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PlayerBtn,
  input  logic       ModeBtn,
  output logic [1:0] mode,
  output logic [7:0] MorsePacked,
  output logic       MorseReady,
  output logic [2:0] sym_count
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [2:0]  SYM_FULL = 3'(MAX_SYMBOLS);

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_DOT  = 2'b01;
  localparam logic [1:0] MODE_DASH = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2
  } state_e;

  // Key conditioning: two-flop synchronizer plus a delayed copy for edges
  logic ply_meta_q, ply_meta_d, ply_sync_q, ply_sync_d, ply_prev_q, ply_prev_d;
  logic mod_meta_q, mod_meta_d, mod_sync_q, mod_sync_d, mod_prev_q, mod_prev_d;
  logic ply_edge, mod_edge;

  // Letter assembly and FSM state
  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  work_q, work_d;
  logic [2:0]  sym_count_q, sym_count_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  packed_q, packed_d;
  logic        ready_q, ready_d;
  logic        accept;

  // Writes a 2-bit symbol code into the given slot of a letter word
  function automatic logic [7:0] put_slot(input logic [7:0] word,
                                          input logic [1:0] idx,
                                          input logic [1:0] code);
    logic [7:0] w;
    w = word;
    case (idx)
      2'd0:    w[7:6] = code;
      2'd1:    w[5:4] = code;
      2'd2:    w[3:2] = code;
      default: w[1:0] = code;
    endcase
    return w;
  endfunction

  // Synchronizer shift: raw key -> meta -> sync -> prev
  always_comb begin
    ply_meta_d = PlayerBtn;
    ply_sync_d = ply_meta_q;
    ply_prev_d = ply_sync_q;
    mod_meta_d = ModeBtn;
    mod_sync_d = mod_meta_q;
    mod_prev_d = mod_sync_q;
  end

  assign ply_edge = ply_sync_q & ~ply_prev_q;
  assign mod_edge = mod_sync_q & ~mod_prev_q;

  // A press counts as a symbol only while a symbol mode is selected
  assign accept = ply_edge && (mode_q != MODE_NONE);

  // Next-state logic: mode cycling, slot writes, gap timing and letter emit
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    state_d     = state_q;
    mode_d      = mode_q;
    work_d      = work_q;
    sym_count_d = sym_count_q;
    gap_d       = gap_q;
    packed_d    = packed_q;
    ready_d     = 1'b0;

    // The symbol below uses mode_q, so a same-cycle mode press only affects
    // later symbols.
    if (mod_edge) begin
      case (mode_q)
        MODE_NONE: mode_d = MODE_DOT;
        MODE_DOT:  mode_d = MODE_DASH;
        default:   mode_d = MODE_NONE;
      endcase
    end

    unique case (state_q)
      S_IDLE: begin
        gap_d = '0;
        if (accept) begin
          work_d      = put_slot(work_q, 2'd0, mode_q);
          sym_count_d = 3'd1;
          state_d     = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (accept) begin
          // An accept always wins over a gap expiry in the same cycle
          work_d      = put_slot(work_q, sym_count_q[1:0], mode_q);
          sym_count_d = sym_count_q + 3'd1;
          gap_d       = '0;
          if (sym_count_d == SYM_FULL) state_d = S_EMIT;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_EMIT;
        end else if (gap_q != 16'hFFFF) begin
          gap_d = gap_q + 16'd1;
        end
      end

      S_EMIT: begin
        // A press landing in the emit cycle opens the next letter directly
        gap_d = '0;
        if (accept) begin
          work_d      = put_slot(8'h00, 2'd0, mode_q);
          sym_count_d = 3'd1;
          state_d     = S_COLLECT;
        end else begin
          work_d      = 8'h00;
          sym_count_d = 3'd0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        work_d      = 8'h00;
        sym_count_d = 3'd0;
        gap_d       = '0;
        state_d     = S_IDLE;
      end
    endcase

    // Publish the finished letter so it is valid throughout the EMIT cycle
    if (state_d == S_EMIT) begin
      packed_d = work_d;
      ready_d  = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling the values from
    // before this edge, independent of statement order.
    if (!rst) begin
      ply_meta_q  <= 1'b0;
      ply_sync_q  <= 1'b0;
      ply_prev_q  <= 1'b0;
      mod_meta_q  <= 1'b0;
      mod_sync_q  <= 1'b0;
      mod_prev_q  <= 1'b0;
      state_q     <= S_IDLE;
      mode_q      <= MODE_NONE;
      work_q      <= 8'h00;
      sym_count_q <= 3'd0;
      gap_q       <= '0;
      packed_q    <= 8'h00;
      ready_q     <= 1'b0;
    end else begin
      ply_meta_q  <= ply_meta_d;
      ply_sync_q  <= ply_sync_d;
      ply_prev_q  <= ply_prev_d;
      mod_meta_q  <= mod_meta_d;
      mod_sync_q  <= mod_sync_d;
      mod_prev_q  <= mod_prev_d;
      state_q     <= state_d;
      mode_q      <= mode_d;
      work_q      <= work_d;
      sym_count_q <= sym_count_d;
      gap_q       <= gap_d;
      packed_q    <= packed_d;
      ready_q     <= ready_d;
    end
  end

  assign mode        = mode_q;
  assign MorsePacked = packed_q;
  assign MorseReady  = ready_q;
  assign sym_count   = sym_count_q;

endmodule
